msgpu_command_processor: RTL and testbench

//  Parametrised MCU command decoder for msgpu. Sits between mcu_bus strobes and the psram framebuffer port.
//  - Decodes command and data bytes into pixel write requests: address set, pixel streaming and rectangle-free fill.
//  - Buffers requests in a FIFO drained by a valid/ready handshake.

---
 rtl/msgpu_command_processor_pkg.sv | 29 ++
 rtl/msgpu_command_processor_if.sv | 24 ++
 rtl/msgpu_request_fifo.sv | 58 +++++
 rtl/msgpu_command_processor.sv | 184 ++++++++++++++++++
 tb/tb_msgpu_command_processor.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/msgpu_command_processor_pkg.sv
// Shared command codes, FSM state encoding and sizing helpers for the msgpu command processor.
package msgpu_command_processor_pkg;

   localparam logic [7:0] CMD_SET_ADDRESS  = 8'h01;
   localparam logic [7:0] CMD_WRITE_PIXELS = 8'h02;
   localparam logic [7:0] CMD_FILL         = 8'h03;
   localparam logic [7:0] CMD_CLEAR_STATUS = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_STREAM,
      ST_FILL_COUNT,
      ST_FILL_PIXEL,
      ST_FILL_RUN
   } state_t;

   // Number of LSB-first bytes needed to carry a field of the given bit width.
   function automatic int unsigned byte_count(input int unsigned width);
      return (width + 32'd7) / 32'd8;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b, input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/msgpu_command_processor_if.sv
// MCU strobe bus plus framebuffer write-request handshake of the command processor.
interface msgpu_command_processor_if #(
   parameter int unsigned ADDR_WIDTH  = 24,
   parameter int unsigned PIXEL_WIDTH = 12
) ();
   logic                   cmd_valid;
   logic [7:0]             cmd_byte;
   logic                   data_valid;
   logic [7:0]             data_byte;
   logic                   wr_valid;
   logic                   wr_ready;
   logic [ADDR_WIDTH-1:0]  wr_address;
   logic [PIXEL_WIDTH-1:0] wr_data;

   modport master (
      input  cmd_valid, cmd_byte, data_valid, data_byte, wr_ready,
      output wr_valid, wr_address, wr_data
   );

   modport slave (
      output cmd_valid, cmd_byte, data_valid, data_byte, wr_ready,
      input  wr_valid, wr_address, wr_data
   );
endinterface

// File: rtl/msgpu_request_fifo.sv
// Synchronous first-word-fall-through FIFO for framebuffer write requests.
module msgpu_request_fifo #(
   parameter  int unsigned WIDTH       = 36,
   parameter  int unsigned DEPTH       = 8,
   localparam int unsigned PTR_WIDTH   = $clog2(DEPTH),
   localparam int unsigned LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [LEVEL_WIDTH-1:0] level
);
   logic [WIDTH-1:0]       mem [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic                   push_ok;
   logic                   pop_ok;
   logic [LEVEL_WIDTH-1:0] level_d;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   always_comb begin
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      level_d = level;
      if (push_ok && !pop_ok)
         level_d = level + LEVEL_WIDTH'(1);
      else if (pop_ok && !push_ok)
         level_d = level - LEVEL_WIDTH'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         level <= level_d;
         full  <= (level_d == LEVEL_WIDTH'(DEPTH));
         empty <= (level_d == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/msgpu_command_processor.sv
// MCU command decoder: turns command/data byte strobes into buffered framebuffer pixel writes.
module msgpu_command_processor
   import msgpu_command_processor_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH  = 24,
   parameter  int unsigned PIXEL_WIDTH = 12,
   parameter  int unsigned COUNT_WIDTH = 16,
   parameter  int unsigned FIFO_DEPTH  = 8,
   localparam int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   msgpu_command_processor_if.master bus,
   output logic                   busy,
   output logic                   overflow,
   output logic [LEVEL_WIDTH-1:0] fifo_level,
   output logic [ADDR_WIDTH-1:0]  cur_address
);
   localparam int unsigned ADDR_BYTES     = byte_count(ADDR_WIDTH);
   localparam int unsigned PIXEL_BYTES    = byte_count(PIXEL_WIDTH);
   localparam int unsigned COUNT_BYTES    = byte_count(COUNT_WIDTH);
   localparam int unsigned MAX_BYTES      = max3(ADDR_BYTES, PIXEL_BYTES, COUNT_BYTES);
   localparam int unsigned BYTE_CNT_WIDTH = $clog2(MAX_BYTES + 1);
   localparam int unsigned ASM_WIDTH      = MAX_BYTES * 8;
   localparam int unsigned ENTRY_WIDTH    = ADDR_WIDTH + PIXEL_WIDTH;

   state_t                    state_q, state_d;
   logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
   logic [ASM_WIDTH-1:0]      asm_q, asm_d, asm_byte_c;
   logic [ADDR_WIDTH-1:0]     cur_address_d;
   logic [COUNT_WIDTH-1:0]    fill_count_q, fill_count_d;
   logic [PIXEL_WIDTH-1:0]    fill_pixel_q, fill_pixel_d;
   logic                      push_valid_q, push_valid_d;
   logic [ADDR_WIDTH-1:0]     push_addr_q, push_addr_d;
   logic [PIXEL_WIDTH-1:0]    push_pixel_q, push_pixel_d;
   logic                      overflow_d, busy_d;
   logic                      fifo_push_c, fifo_pop_c, fifo_full, fifo_empty;
   logic                      fill_push_c, last_byte_c;
   int unsigned               need_bytes_c;
   logic [ENTRY_WIDTH-1:0]    fifo_din_c, fifo_dout;

   // Assembly register with the incoming byte dropped into its LSB-first slot.
   always_comb begin
      asm_byte_c = asm_q;
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
         if (byte_cnt_q == BYTE_CNT_WIDTH'(i)) asm_byte_c[i*8 +: 8] = bus.data_byte;
      end
   end

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      asm_d         = asm_q;
      cur_address_d = cur_address;
      fill_count_d  = fill_count_q;
      fill_pixel_d  = fill_pixel_q;
      push_valid_d  = 1'b0;
      push_addr_d   = push_addr_q;
      push_pixel_d  = push_pixel_q;
      overflow_d    = overflow;
      fifo_pop_c    = bus.wr_valid && bus.wr_ready;
      fill_push_c   = (state_q == ST_FILL_RUN) && !bus.cmd_valid && (!fifo_full || fifo_pop_c);

      case (state_q)
         ST_ADDR:       need_bytes_c = ADDR_BYTES;
         ST_FILL_COUNT: need_bytes_c = COUNT_BYTES;
         default:       need_bytes_c = PIXEL_BYTES;
      endcase
      last_byte_c = (byte_cnt_q == BYTE_CNT_WIDTH'(need_bytes_c - 1));

      if (bus.cmd_valid) begin
         // Any command abandons partially collected bytes and any remaining fill.
         byte_cnt_d = '0;
         asm_d      = '0;
         case (bus.cmd_byte)
            CMD_SET_ADDRESS:  state_d = ST_ADDR;
            CMD_WRITE_PIXELS: state_d = ST_STREAM;
            CMD_FILL:         state_d = ST_FILL_COUNT;
            CMD_CLEAR_STATUS: begin
               state_d    = ST_IDLE;
               overflow_d = 1'b0;
            end
            default:          state_d = ST_IDLE;
         endcase
      end else begin
         case (state_q)
            ST_ADDR, ST_STREAM, ST_FILL_COUNT, ST_FILL_PIXEL: begin
               if (bus.data_valid) begin
                  if (last_byte_c) begin
                     byte_cnt_d = '0;
                     asm_d      = '0;
                     case (state_q)
                        ST_ADDR: begin
                           cur_address_d = ADDR_WIDTH'(asm_byte_c);
                           state_d       = ST_IDLE;
                        end
                        ST_STREAM: begin
                           push_valid_d  = 1'b1;
                           push_addr_d   = cur_address;
                           push_pixel_d  = PIXEL_WIDTH'(asm_byte_c);
                           cur_address_d = cur_address + ADDR_WIDTH'(1);
                        end
                        ST_FILL_COUNT: begin
                           fill_count_d = COUNT_WIDTH'(asm_byte_c);
                           state_d      = ST_FILL_PIXEL;
                        end
                        default: begin
                           fill_pixel_d = PIXEL_WIDTH'(asm_byte_c);
                           state_d      = (fill_count_q == '0) ? ST_IDLE : ST_FILL_RUN;
                        end
                     endcase
                  end else begin
                     asm_d      = asm_byte_c;
                     byte_cnt_d = byte_cnt_q + BYTE_CNT_WIDTH'(1);
                  end
               end
            end
            ST_FILL_RUN: begin
               if (fill_push_c) begin
                  cur_address_d = cur_address + ADDR_WIDTH'(1);
                  fill_count_d  = fill_count_q - COUNT_WIDTH'(1);
                  if (fill_count_q == COUNT_WIDTH'(1)) state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end

      // A streamed pixel that finds the FIFO full with no departing head is lost.
      if (push_valid_q && fifo_full && !fifo_pop_c) overflow_d = 1'b1;

      fifo_push_c = push_valid_q || fill_push_c;
      fifo_din_c  = push_valid_q ? {push_addr_q, push_pixel_q} : {cur_address, fill_pixel_q};
      busy_d      = !(state_d inside {ST_IDLE, ST_STREAM});
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         asm_q        <= '0;
         cur_address  <= '0;
         fill_count_q <= '0;
         fill_pixel_q <= '0;
         push_valid_q <= 1'b0;
         push_addr_q  <= '0;
         push_pixel_q <= '0;
         overflow     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         cur_address  <= cur_address_d;
         fill_count_q <= fill_count_d;
         fill_pixel_q <= fill_pixel_d;
         push_valid_q <= push_valid_d;
         push_addr_q  <= push_addr_d;
         push_pixel_q <= push_pixel_d;
         overflow     <= overflow_d;
         busy         <= busy_d;
      end
   end

   msgpu_request_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifo_push_c),
      .din     (fifo_din_c),
      .pop     (fifo_pop_c),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bus.wr_valid   = !fifo_empty;
   assign bus.wr_address = fifo_dout[ENTRY_WIDTH-1:PIXEL_WIDTH];
   assign bus.wr_data    = fifo_dout[PIXEL_WIDTH-1:0];

endmodule

// File: tb/tb_msgpu_command_processor.sv
// Directed scoreboard bench for msgpu_command_processor: stimulus queues expected writes, a monitor checks them.
module tb_msgpu_command_processor;
   import msgpu_command_processor_pkg::*;

   localparam int unsigned AW    = 24;
   localparam int unsigned PW    = 12;
   localparam int unsigned CW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          reset_n;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] fifo_level;
   logic [AW-1:0] cur_address;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+PW-1:0] exp_q[$];

   always #5 clock = ~clock;

   msgpu_command_processor_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) bus ();

   msgpu_command_processor #(
      .ADDR_WIDTH  (AW),
      .PIXEL_WIDTH (PW),
      .COUNT_WIDTH (CW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .busy        (busy),
      .overflow    (overflow),
      .fifo_level  (fifo_level),
      .cur_address (cur_address)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Handshake values are stable from just after the falling edge until the rising edge that commits them.
   initial begin
      logic [AW+PW-1:0] e;
      forever begin
         @(negedge clock);
         #2;
         if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got addr 0x%0h data 0x%0h with no write expected", bus.wr_address, bus.wr_data);
            end else begin
               e = exp_q.pop_front();
               check("sb_address", 32'(bus.wr_address), 32'(e[AW+PW-1:PW]));
               check("sb_data", 32'(bus.wr_data), 32'(e[PW-1:0]));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus tasks are entered at a falling edge and return at the next one.
   task automatic send_cmd(input logic [7:0] c);
      bus.cmd_valid = 1'b1;
      bus.cmd_byte  = c;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] d);
      bus.data_valid = 1'b1;
      bus.data_byte  = d;
      @(negedge clock);
      bus.data_valid = 1'b0;
   endtask

   task automatic send_pixel(input logic [11:0] p);
      send_data(p[7:0]);
      send_data({4'h0, p[11:8]});
   endtask

   task automatic set_address(input logic [23:0] a);
      send_cmd(CMD_SET_ADDRESS);
      send_data(a[7:0]);
      send_data(a[15:8]);
      send_data(a[23:16]);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic expect_write(input logic [23:0] a, input logic [11:0] p);
      exp_q.push_back({a, p});
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (fifo_level != '0 && k < budget) begin
         @(negedge clock);
         k++;
      end
      idle_cycles(1);
      check({name, "_level"}, 32'(fifo_level), 32'd0);
      check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_byte   = 8'h00;
      bus.data_valid = 1'b0;
      bus.data_byte  = 8'h00;
      bus.wr_ready   = 1'b0;
      idle_cycles(2);
      check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_cur_address", 32'(cur_address), 32'd0);
      reset_n = 1'b1;
      idle_cycles(1);

      // Address set then a single streamed pixel, with latency check
      bus.wr_ready = 1'b1;
      set_address(24'h001234);
      check("t1_addr_busy_idle", 32'(busy), 32'd0);
      send_cmd(CMD_WRITE_PIXELS);
      expect_write(24'h001234, 12'hCAB);
      send_data(8'hAB);
      send_data(8'h0C);
      check("t1_wr_valid_early", 32'(bus.wr_valid), 32'd0);
      idle_cycles(1);
      check("t1_wr_valid_due", 32'(bus.wr_valid), 32'd1);
      check("t1_wr_address", 32'(bus.wr_address), 32'h001234);
      idle_cycles(2);
      check("t1_cur_address", 32'(cur_address), 32'h001235);
      drain("t1", 20);

      // Address wrap while streaming
      set_address(24'hFFFFFF);
      send_cmd(CMD_WRITE_PIXELS);
      expect_write(24'hFFFFFF, 12'h111);
      expect_write(24'h000000, 12'h222);
      send_pixel(12'h111);
      send_pixel(12'h222);
      idle_cycles(3);
      check("t2_cur_address", 32'(cur_address), 32'h000001);
      drain("t2", 20);

      // FILL of five with the consumer stalled
      bus.wr_ready = 1'b0;
      send_cmd(CMD_FILL);
      send_data(8'h05);
      send_data(8'h00);
      for (int i = 1; i <= 5; i++) expect_write(24'(i), 12'h00F);
      send_data(8'h0F);
      send_data(8'h00);
      check("t3_busy_start", 32'(busy), 32'd1);
      idle_cycles(4);
      check("t3_busy_running", 32'(busy), 32'd1);
      check("t3_level4", 32'(fifo_level), 32'd4);
      idle_cycles(1);
      check("t3_level5", 32'(fifo_level), 32'd5);
      check("t3_busy_done", 32'(busy), 32'd0);
      check("t3_overflow", 32'(overflow), 32'd0);
      check("t3_cur_address", 32'(cur_address), 32'h000006);
      bus.wr_ready = 1'b1;
      drain("t3", 30);

      // Stream nine pixels into an eight-entry FIFO
      bus.wr_ready = 1'b0;
      send_cmd(CMD_WRITE_PIXELS);
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_write(24'(6 + i), 12'(12'h100 + i));
         send_pixel(12'(12'h100 + i));
      end
      idle_cycles(3);
      check("t4_level_full", 32'(fifo_level), 32'd8);
      check("t4_overflow_set", 32'(overflow), 32'd1);
      check("t4_cur_address", 32'(cur_address), 32'h00000F);
      check("t4_head_stable", 32'(bus.wr_address), 32'h000006);
      send_cmd(CMD_CLEAR_STATUS);
      check("t4_overflow_clear", 32'(overflow), 32'd0);
      bus.wr_ready = 1'b1;
      drain("t4", 40);

      // Long FILL cancelled by a command after three pushes; partial address discarded
      bus.wr_ready = 1'b0;
      send_cmd(CMD_FILL);
      send_data(8'h00);
      send_data(8'h01);
      expect_write(24'h00000F, 12'h123);
      expect_write(24'h000010, 12'h123);
      expect_write(24'h000011, 12'h123);
      send_data(8'h23);
      send_data(8'h01);
      idle_cycles(3);
      send_cmd(CMD_WRITE_PIXELS);
      check("t5_level_abort", 32'(fifo_level), 32'd3);
      check("t5_busy_abort", 32'(busy), 32'd0);
      idle_cycles(2);
      check("t5_level_held", 32'(fifo_level), 32'd3);
      check("t5_cur_address", 32'(cur_address), 32'h000012);
      send_cmd(CMD_SET_ADDRESS);
      send_data(8'h55);
      check("t5_busy_addr", 32'(busy), 32'd1);
      send_data(8'h66);
      send_cmd(CMD_CLEAR_STATUS);
      check("t5_partial_addr", 32'(cur_address), 32'h000012);
      bus.wr_ready = 1'b1;
      drain("t5", 20);

      // Reset in the middle of a FILL with four entries queued
      bus.wr_ready = 1'b0;
      send_cmd(CMD_FILL);
      send_data(8'h10);
      send_data(8'h00);
      send_data(8'hAA);
      send_data(8'h0A);
      idle_cycles(4);
      check("t6_level_before", 32'(fifo_level), 32'd4);
      reset_n = 1'b0;
      idle_cycles(1);
      reset_n = 1'b1;
      check("t6_wr_valid", 32'(bus.wr_valid), 32'd0);
      check("t6_level", 32'(fifo_level), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_cur_address", 32'(cur_address), 32'd0);
      idle_cycles(2);
      check("t6_no_resume", 32'(fifo_level), 32'd0);

      // Command and data in the same cycle: the data byte is dropped
      bus.cmd_valid  = 1'b1;
      bus.cmd_byte   = CMD_WRITE_PIXELS;
      bus.data_valid = 1'b1;
      bus.data_byte  = 8'h77;
      idle_cycles(1);
      bus.cmd_valid  = 1'b0;
      bus.data_valid = 1'b0;
      expect_write(24'h000000, 12'h988);
      send_pixel(12'h988);
      bus.wr_ready = 1'b1;
      idle_cycles(3);
      check("t6_cur_after", 32'(cur_address), 32'd1);
      drain("t6", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
